// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Brief    : Valid/ready instruction sequencer driving a single-cycle ALU,
//            with accumulator, carry flag and backpressured result port.
//            Optional zero flag enabled by macro ALU_SEQ_ZERO_FLAG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int SIZE = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [2:0]      instr_op,
  input  logic [SIZE-1:0] instr_operand,
  input  logic            instr_use_carry,
  output logic            alu_ce,
  output logic [2:0]      alu_op_code,
  output logic [SIZE-1:0] alu_left,
  output logic [SIZE-1:0] alu_right,
  output logic            alu_carry_in,
  input  logic [SIZE-1:0] alu_op_out,
  input  logic            alu_carry_out,
  output logic [SIZE-1:0] acc,
  output logic            carry_flag,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [SIZE-1:0] res_data,
  output logic            res_store
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic            zero_flag
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ST  = 3'd7;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       accept;
  logic       capture;

  assign accept  = (state == S_IDLE) && instr_valid;
  assign capture = (state == S_EXEC);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (instr_valid) state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    if (res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    alu_ce      = 1'b0;
    res_valid   = 1'b0;
    case (state)
      S_IDLE:  instr_ready = 1'b1;
      S_EXEC:  alu_ce      = 1'b1;
      S_WB:    res_valid   = 1'b1;
      default: instr_ready = 1'b0;
    endcase
  end

  // ALU operands are registered at accept so they are stable for the whole EXEC cycle;
  // carry_flag cannot change between accept and EXEC, so the carry-in is latched too.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_op_code  <= 3'd0;
      alu_left     <= '0;
      alu_right    <= '0;
      alu_carry_in <= 1'b0;
    end else if (accept) begin
      alu_op_code  <= instr_op;
      alu_left     <= acc;
      alu_right    <= instr_operand;
      alu_carry_in <= instr_use_carry & carry_flag;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc        <= '0;
      carry_flag <= 1'b0;
      res_data   <= '0;
      res_store  <= 1'b0;
    end else if (capture) begin
      res_data  <= alu_op_out;
      res_store <= (alu_op_code == OP_ST);
      if (alu_op_code != OP_ST) begin
        acc <= alu_op_out;
      end
      if ((alu_op_code == OP_ADD) || (alu_op_code == OP_SUB)) begin
        carry_flag <= alu_carry_out;
      end
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      zero_flag <= 1'b0;
    end else if (capture && (alu_op_code != OP_ST)) begin
      zero_flag <= (alu_op_out == '0);
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer with an ALU model and an
//            arithmetic reference model of the accumulator machine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   instr_op;
  logic [W-1:0] instr_operand;
  logic         instr_use_carry;
  logic         alu_ce;
  logic [2:0]   alu_op_code;
  logic [W-1:0] alu_left;
  logic [W-1:0] alu_right;
  logic         alu_carry_in;
  logic [W-1:0] alu_op_out;
  logic         alu_carry_out;
  logic [W-1:0] acc;
  logic         carry_flag;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_store;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic         zero_flag;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int m_acc, m_cf, m_zf, m_res, m_store;

  alu_sequencer #(.SIZE(W)) dut (
    .CLK            (clk),
    .RST_N          (rst_n),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_op       (instr_op),
    .instr_operand  (instr_operand),
    .instr_use_carry(instr_use_carry),
    .alu_ce         (alu_ce),
    .alu_op_code    (alu_op_code),
    .alu_left       (alu_left),
    .alu_right      (alu_right),
    .alu_carry_in   (alu_carry_in),
    .alu_op_out     (alu_op_out),
    .alu_carry_out  (alu_carry_out),
    .acc            (acc),
    .carry_flag     (carry_flag),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_store      (res_store)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    .zero_flag      (zero_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU attached to the sequencer; (W+1)-bit result supplies the carry.
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (alu_op_code)
      3'd0: alu_sum = {1'b0, alu_left} + {1'b0, alu_right} + {{W{1'b0}}, alu_carry_in};
      3'd1: alu_sum = {1'b0, alu_left} - {1'b0, alu_right} - {{W{1'b0}}, alu_carry_in};
      3'd2: alu_sum = {1'b0, alu_left & alu_right};
      3'd3: alu_sum = {1'b0, alu_left | alu_right};
      3'd4: alu_sum = {1'b0, alu_left ^ alu_right};
      3'd5: alu_sum = {1'b0, ~alu_left};
      3'd6: alu_sum = {1'b0, alu_right};
      default: alu_sum = {1'b0, alu_left};
    endcase
  end
  assign alu_op_out    = alu_sum[W-1:0];
  assign alu_carry_out = alu_sum[W];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cf = 0; m_zf = 0; m_res = 0; m_store = 0;
  endtask

  task automatic model_apply(input int op, input int opnd, input int uc);
    int cin, t, new_cf;
    cin    = (uc != 0 && m_cf != 0) ? 1 : 0;
    new_cf = m_cf;
    case (op)
      0: begin t = m_acc + opnd + cin; m_res = t % 256; new_cf = (t > 255) ? 1 : 0; end
      1: begin t = m_acc - opnd - cin; m_res = (t + 256) % 256; new_cf = (t < 0) ? 1 : 0; end
      2: m_res = m_acc & opnd;
      3: m_res = m_acc | opnd;
      4: m_res = m_acc ^ opnd;
      5: m_res = 255 - m_acc;
      6: m_res = opnd;
      default: m_res = m_acc;
    endcase
    m_store = (op == 7) ? 1 : 0;
    if (op != 7) begin
      m_acc = m_res;
      m_zf  = (m_res == 0) ? 1 : 0;
    end
    if (op < 2) m_cf = new_cf;
  endtask

  task automatic run_instr(input int op, input int opnd, input int uc, input int stall);
    int exp_left, exp_cin;
    check_val("idle_ready", 32'(instr_ready), 32'd1);
    instr_valid     = 1'b1;
    instr_op        = 3'(op);
    instr_operand   = W'(opnd);
    instr_use_carry = uc[0];
    res_ready       = 1'b1;
    exp_left = m_acc;
    exp_cin  = (uc != 0 && m_cf != 0) ? 1 : 0;
    @(posedge clk); @(negedge clk);
    check_val("exec_ce", 32'(alu_ce), 32'd1);
    check_val("exec_res_valid", 32'(res_valid), 32'd0);
    check_val("exec_ready", 32'(instr_ready), 32'd0);
    check_val("exec_op", 32'(alu_op_code), 32'(op));
    check_val("exec_left", 32'(alu_left), 32'(exp_left));
    check_val("exec_right", 32'(alu_right), 32'(opnd));
    check_val("exec_cin", 32'(alu_carry_in), 32'(exp_cin));
    instr_valid   = (stall > 0);
    instr_op      = 3'($urandom_range(0, 7));
    instr_operand = W'($urandom_range(0, 255));
    res_ready     = (stall == 0);
    @(posedge clk); @(negedge clk);
    model_apply(op, opnd, uc);
    check_val("wb_res_valid", 32'(res_valid), 32'd1);
    check_val("wb_ce", 32'(alu_ce), 32'd0);
    check_val("wb_acc", 32'(acc), 32'(m_acc));
    check_val("wb_carry", 32'(carry_flag), 32'(m_cf));
    check_val("wb_res_data", 32'(res_data), 32'(m_res));
    check_val("wb_res_store", 32'(res_store), 32'(m_store));
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check_val("wb_zero", 32'(zero_flag), 32'(m_zf));
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      check_val("stall_res_valid", 32'(res_valid), 32'd1);
      check_val("stall_res_data", 32'(res_data), 32'(m_res));
      check_val("stall_res_store", 32'(res_store), 32'(m_store));
      check_val("stall_ready", 32'(instr_ready), 32'd0);
      check_val("stall_ce", 32'(alu_ce), 32'd0);
      if (i == stall - 1) begin
        res_ready   = 1'b1;
        instr_valid = 1'b0;
      end
    end
    @(posedge clk); @(negedge clk);
    check_val("ret_res_valid", 32'(res_valid), 32'd0);
    check_val("ret_ready", 32'(instr_ready), 32'd1);
    check_val("ret_ce", 32'(alu_ce), 32'd0);
    check_val("ret_acc", 32'(acc), 32'(m_acc));
  endtask

  // Assert reset a couple of time units after an edge, while in EXEC (wb=0) or WB (wb=1).
  task automatic mid_reset(input int op, input int opnd, input int wb);
    instr_valid     = 1'b1;
    instr_op        = 3'(op);
    instr_operand   = W'(opnd);
    instr_use_carry = 1'b0;
    res_ready       = 1'b0;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    if (wb != 0) begin
      @(posedge clk); @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_ce", 32'(alu_ce), 32'd0);
    check_val("arst_acc", 32'(acc), 32'd0);
    check_val("arst_carry", 32'(carry_flag), 32'd0);
    check_val("arst_res_valid", 32'(res_valid), 32'd0);
    check_val("arst_res_data", 32'(res_data), 32'd0);
    check_val("arst_res_store", 32'(res_store), 32'd0);
    check_val("arst_op_code", 32'(alu_op_code), 32'd0);
    check_val("arst_left", 32'(alu_left), 32'd0);
    check_val("arst_right", 32'(alu_right), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    model_reset();
    @(negedge clk);
    check_val("post_rst_ready", 32'(instr_ready), 32'd1);
    check_val("post_rst_res_valid", 32'(res_valid), 32'd0);
    check_val("post_rst_acc", 32'(acc), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = 3'd0; instr_operand = '0;
    instr_use_carry = 1'b0; res_ready = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_acc", 32'(acc), 32'd0);
    check_val("rst_carry", 32'(carry_flag), 32'd0);
    check_val("rst_ce", 32'(alu_ce), 32'd0);
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_ready", 32'(instr_ready), 32'd1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check_val("rst_zero", 32'(zero_flag), 32'd0);
`endif

    // Add with carry chain
    run_instr(6, 8'hF0, 0, 0);
    check_val("chain_ld", 32'(acc), 32'h0F0);
    run_instr(0, 8'h20, 0, 0);
    check_val("chain_add1_acc", 32'(acc), 32'h010);
    check_val("chain_add1_c", 32'(carry_flag), 32'd1);
    run_instr(0, 8'h01, 1, 0);
    check_val("chain_add2_acc", 32'(acc), 32'h012);
    check_val("chain_add2_c", 32'(carry_flag), 32'd0);

    // Subtract with borrow
    run_instr(6, 8'h05, 0, 0);
    run_instr(1, 8'h03, 0, 0);
    check_val("sub1_acc", 32'(acc), 32'h002);
    check_val("sub1_c", 32'(carry_flag), 32'd0);
    run_instr(1, 8'h06, 0, 0);
    check_val("sub2_acc", 32'(acc), 32'h0FC);
    check_val("sub2_c", 32'(carry_flag), 32'd1);

    // Logic and store; carry remains set through these
    run_instr(6, 8'hA5, 0, 0);
    run_instr(4, 8'hFF, 0, 0);
    check_val("xor_acc", 32'(acc), 32'h05A);
    check_val("xor_c", 32'(carry_flag), 32'd1);
    run_instr(7, 8'h00, 0, 3);
    check_val("st_res", 32'(res_data), 32'h05A);
    check_val("st_acc", 32'(acc), 32'h05A);
    run_instr(5, 8'h00, 0, 0);
    check_val("not_acc", 32'(acc), 32'h0A5);

    // Reset during EXEC of ADD 0x01, then during WB
    mid_reset(0, 8'h01, 0);
    run_instr(6, 8'h00, 0, 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check_val("ld0_zero", 32'(zero_flag), 32'd1);
`endif
    run_instr(6, 8'h77, 0, 1);
    mid_reset(0, 8'h11, 1);

    for (int n = 0; n < 60; n++) begin
      run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
